// File: rtl/manchester_line_tx.sv
// manchester_line_tx: Manchester line transmitter with lock preamble, stop gap and half-bit rate trim
module manchester_line_tx #(
    parameter int DIV           = 8,
    parameter int PREAMBLE_BITS = 16,
    parameter int STOP_BITS     = 2
) (
    input  logic       MainClock,
    input  logic       ResetN,
    input  logic [7:0] TxData,
    input  logic       TxValid,
    output logic       TxReady,
    input  logic       RateAdvance,
    input  logic       RateRetard,
    output logic       SignalOut,
    output logic       BitStrobe,
    output logic       Busy
);
    localparam int CW   = $clog2(DIV + 2);
    localparam int MAXA = PREAMBLE_BITS > 8 ? PREAMBLE_BITS : 8;
    localparam int MAXB = MAXA > 2 * STOP_BITS ? MAXA : 2 * STOP_BITS;
    localparam int BW   = $clog2(MAXB + 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, STOP} stateType;

    stateType      state, stateNext;
    logic [CW-1:0] cnt, lastCnt;
    logic [BW-1:0] bitCnt;
    logic [7:0]    shiftReg, holdReg;
    logic          half, holdFull, advFlag, retFlag;
    logic          terminal, accept, bitEnd, preDone, byteDone, load;

    // Half-bit length follows the trim seen so far; opposing trims cancel
    always_comb begin
        lastCnt  = (advFlag && !retFlag) ? CW'(DIV - 2) : (retFlag && !advFlag) ? CW'(DIV) : CW'(DIV - 1);
        terminal = (state != IDLE) && (cnt >= lastCnt);
        accept   = TxValid && !holdFull;
        bitEnd   = terminal && half && (state == PREAMBLE || state == DATA);
        preDone  = bitEnd && state == PREAMBLE && bitCnt == BW'(PREAMBLE_BITS - 1);
        byteDone = bitEnd && state == DATA && bitCnt == BW'(7);
        load     = preDone || (byteDone && holdFull);
    end

    // Frame sequencing and line outputs
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:     if (accept || holdFull) stateNext = PREAMBLE;
            PREAMBLE: if (preDone) stateNext = DATA;
            DATA:     if (byteDone && !holdFull) stateNext = STOP;
            STOP:     if (terminal && bitCnt == BW'(2 * STOP_BITS - 1)) stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
        SignalOut = (state == PREAMBLE) ? !half : (state == DATA) ? (shiftReg[7] ^ !half) : 1'b0;
        BitStrobe = bitEnd;
        Busy      = state != IDLE;
        TxReady   = !holdFull;
    end

    // State register
    always_ff @(posedge MainClock or negedge ResetN) begin
        if (!ResetN) state <= IDLE;
        else         state <= stateNext;
    end

    // Holding/shift registers, half-bit timer, bit counter and trim flags
    always_ff @(posedge MainClock or negedge ResetN) begin
        if (!ResetN) begin
            cnt      <= '0;
            half     <= 1'b0;
            bitCnt   <= '0;
            shiftReg <= '0;
            holdReg  <= '0;
            holdFull <= 1'b0;
            advFlag  <= 1'b0;
            retFlag  <= 1'b0;
        end else begin
            if (accept) begin
                holdReg  <= TxData;
                holdFull <= 1'b1;
            end else if (load) begin
                holdFull <= 1'b0;
            end
            if (load) shiftReg <= holdReg;
            else if (bitEnd && state == DATA) shiftReg <= {shiftReg[6:0], 1'b0};
            if (state == IDLE) begin
                cnt     <= '0;
                half    <= 1'b0;
                bitCnt  <= '0;
                advFlag <= 1'b0;
                retFlag <= 1'b0;
            end else if (terminal) begin
                cnt     <= '0;
                half    <= !half;
                advFlag <= RateAdvance;
                retFlag <= RateRetard;
                if (state == STOP || half)
                    bitCnt <= (stateNext != state || byteDone) ? '0 : bitCnt + 1'b1;
            end else begin
                cnt     <= cnt + 1'b1;
                advFlag <= advFlag | RateAdvance;
                retFlag <= retFlag | RateRetard;
            end
        end
    end
endmodule

// File: tb/tb_manchester_line_tx.sv
// tb_manchester_line_tx: queue-of-half-bits reference model checked against the transmitter every cycle
module tb_manchester_line_tx;
    localparam int DIV   = 8;
    localparam int PRE   = 4;
    localparam int STOPB = 2;

    logic       MainClock, ResetN, TxValid, TxReady, RateAdvance, RateRetard;
    logic       SignalOut, BitStrobe, Busy;
    logic [7:0] TxData;

    manchester_line_tx #(.DIV(DIV), .PREAMBLE_BITS(PRE), .STOP_BITS(STOPB)) dut (
        .MainClock(MainClock), .ResetN(ResetN), .TxData(TxData), .TxValid(TxValid),
        .TxReady(TxReady), .RateAdvance(RateAdvance), .RateRetard(RateRetard),
        .SignalOut(SignalOut), .BitStrobe(BitStrobe), .Busy(Busy)
    );

    initial MainClock = 1'b0;
    always #5 MainClock = ~MainClock;

    int checks = 0;
    int failures = 0;
    int busyCnt, strobeCnt;
    logic sigLog [0:511];

    // Model: each queued half-bit = {dataEnd, preambleEnd, strobe, level}
    logic [3:0] halves[$];
    logic       mBusy, mHoldFull, mAdv, mRet;
    logic [7:0] mHold;
    int         mPos;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mLast();
        return (mAdv && !mRet) ? DIV - 2 : (mRet && !mAdv) ? DIV : DIV - 1;
    endfunction

    task automatic pushByte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            halves.push_back({1'b0, 1'b0, 1'b0, ~b[i]});
            halves.push_back({i == 0, 1'b0, 1'b1, b[i]});
        end
    endtask

    task automatic pushPreamble();
        for (int i = 0; i < PRE; i++) begin
            halves.push_back(4'b0001);
            halves.push_back({1'b0, i == PRE - 1, 1'b1, 1'b0});
        end
    endtask

    task automatic pushStop();
        for (int i = 0; i < 2 * STOPB; i++) halves.push_back(4'b0000);
    endtask

    task automatic modelReset();
        mBusy = 0; mHoldFull = 0; mHold = 0; mPos = 0; mAdv = 0; mRet = 0;
        halves.delete();
    endtask

    task automatic modelStep();
        logic wasIdle, acc;
        logic [3:0] h;
        wasIdle = !mBusy;
        acc = TxValid && !mHoldFull;
        if (mBusy) begin
            if (mPos >= mLast()) begin
                h = halves.pop_front();
                mPos = 0; mAdv = RateAdvance; mRet = RateRetard;
                if (h[2] || (h[3] && mHoldFull)) begin
                    pushByte(mHold);
                    mHoldFull = 0;
                end else if (h[3]) begin
                    pushStop();
                end
                if (halves.size() == 0) mBusy = 0;
            end else begin
                mPos++; mAdv = mAdv | RateAdvance; mRet = mRet | RateRetard;
            end
        end
        if (acc) begin mHoldFull = 1; mHold = TxData; end
        if (wasIdle && mHoldFull) begin
            mBusy = 1; mPos = 0; mAdv = 0; mRet = 0;
            pushPreamble();
        end
    endtask

    // One clock: advance the model at the edge, compare at the falling edge
    task automatic tick();
        logic [3:0] hd;
        @(posedge MainClock);
        if (!ResetN) modelReset(); else modelStep();
        @(negedge MainClock);
        hd = mBusy ? halves[0] : 4'b0000;
        check("SignalOut", SignalOut, mBusy ? hd[0] : 0);
        check("BitStrobe", BitStrobe, (mBusy && hd[1] && mPos >= mLast()) ? 1 : 0);
        check("Busy", Busy, mBusy);
        check("TxReady", TxReady, !mHoldFull);
        if (Busy) begin
            if (busyCnt < 512) sigLog[busyCnt] = SignalOut;
            busyCnt++;
        end
        if (BitStrobe) strobeCnt++;
        RateAdvance = 0;
        RateRetard = 0;
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        for (n = 0; n < 2000 && !TxReady; n++) begin
            TxValid = 1; TxData = 8'($urandom); tick();
        end
        check("send_timeout", n < 2000, 1);
        TxValid = 1; TxData = d; tick();
        TxValid = 0;
    endtask

    task automatic waitIdle();
        int n;
        for (n = 0; n < 3000 && Busy; n++) tick();
        check("idle_timeout", n < 3000, 1);
    endtask

    task automatic trimFrame(input string name, input int adv, input int ret, input int exp);
        busyCnt = 0;
        send(8'h3C);
        for (int i = 0; i < 3; i++) begin
            RateAdvance = adv[i];
            RateRetard = ret[i];
            tick();
        end
        waitIdle();
        check(name, busyCnt, exp);
    endtask

    initial begin
        int n;
        ResetN = 0; TxValid = 0; TxData = 0; RateAdvance = 0; RateRetard = 0;
        busyCnt = 0; strobeCnt = 0;
        modelReset();
        repeat (3) tick();
        check("rst_SignalOut", SignalOut, 0);
        check("rst_TxReady", TxReady, 1);
        check("rst_Busy", Busy, 0);
        check("rst_BitStrobe", BitStrobe, 0);
        ResetN = 1;
        tick();

        busyCnt = 0; strobeCnt = 0;
        send(8'hA5);
        waitIdle();
        check("a5_busy_cycles", busyCnt, 224);
        check("a5_strobes", strobeCnt, 12);
        check("a5_pre_first_half", sigLog[0], 1);
        check("a5_pre_second_half", sigLog[8], 0);
        check("a5_bit7_first_half", sigLog[64], 0);
        check("a5_bit7_second_half", sigLog[72], 1);
        check("a5_bit6_first_half", sigLog[80], 1);
        check("a5_stop_low", sigLog[200], 0);

        trimFrame("trim_advance", 1, 0, 223);
        trimFrame("trim_retard", 0, 1, 225);
        trimFrame("trim_both_same", 1, 1, 224);
        trimFrame("trim_both_half", 1, 2, 224);
        trimFrame("trim_three_adv", 7, 0, 223);

        busyCnt = 0; strobeCnt = 0;
        send(8'h00);
        send(8'hFF);
        waitIdle();
        check("pair_busy_cycles", busyCnt, 352);
        check("pair_strobes", strobeCnt, 20);

        busyCnt = 0; strobeCnt = 0;
        send(8'h5A);
        for (n = 0; n < 1000 && strobeCnt < 12; n++) tick();
        check("strobe_timeout", n < 1000, 1);
        repeat (4) tick();
        send(8'hC3);
        waitIdle();
        tick();
        waitIdle();
        check("stop_accept_busy", busyCnt, 448);
        check("stop_accept_strobes", strobeCnt, 24);

        send(8'h96);
        repeat (70) tick();
        send(8'h11);
        repeat (54) tick();
        check("pre_rst_ready", TxReady, 0);
        check("pre_rst_busy", Busy, 1);
        #2 ResetN = 0;
        modelReset();
        #1;
        check("async_SignalOut", SignalOut, 0);
        check("async_Busy", Busy, 0);
        check("async_TxReady", TxReady, 1);
        tick();
        ResetN = 1;
        tick();
        busyCnt = 0;
        send(8'hE7);
        waitIdle();
        check("after_rst_busy", busyCnt, 224);

        for (int i = 0; i < 4000; i++) begin
            TxValid = ($urandom % 4) == 0;
            TxData = 8'($urandom);
            RateAdvance = ($urandom % 12) == 0;
            RateRetard = ($urandom % 12) == 0;
            tick();
        end
        TxValid = 0;
        waitIdle();
        tick();
        waitIdle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
